// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and defaults for the PC redirect controller and its fetch watchdog.
package pc_redirect_ctrl_pkg;

  localparam int unsigned INST_ADDR_BUS   = 32;
  localparam int unsigned PCR_TIMEOUT_DEF = 255;

  typedef enum logic [0:0] {
    PCR_IDLE = 1'b0,
    PCR_PEND = 1'b1
  } pcr_state_t;

endpackage

// File: rtl/pc_redirect_ctrl_fetch_watchdog.sv
// Fetch-stall watchdog: counts consecutive not-ready cycles, pulses bus_err on expiry.
module fetch_watchdog
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = PCR_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_ready_i,
  output logic bus_err_o
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;
  logic          expired;

  assign expired = (cnt == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bus_err_o <= 1'b0;
    end else if (fetch_ready_i) begin
      cnt       <= '0;
      bus_err_o <= 1'b0;
    end else if (expired) begin
      cnt       <= '0;
      bus_err_o <= 1'b1;
    end else begin
      // Saturate rather than wrap; unreachable while the expiry restart works.
      if (cnt != '1) cnt <= cnt + 1'b1;
      bus_err_o <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect arbitration: trap/branch selection, stalled-redirect replay and stall merge.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = INST_ADDR_BUS,
  parameter int unsigned TIMEOUT_CYC = PCR_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              br_req_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic              hold_ex_i,
  input  logic              hold_id_i,
  input  logic              fetch_ready_i,
  output logic              jmp_en_o,
  output logic [ADDR_W-1:0] jmp_addr_o,
  output logic              hold_o,
  output logic              flush_o,
  output logic              pend_o,
  output logic              bus_err_o
);

  pcr_state_t        state;
  logic [ADDR_W-1:0] pend_addr;
  logic              req;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] trap_al;
  logic              jmp_en;
  logic [ADDR_W-1:0] jmp_addr;
  logic              flush;
  logic              hold;
  logic              wd_err;

  assign req      = trap_req_i | br_req_i;
  assign trap_al  = {trap_addr_i[ADDR_W-1:2], 2'b00};
  assign sel_addr = trap_req_i ? trap_al : {br_addr_i[ADDR_W-1:2], 2'b00};

  always_comb begin
    jmp_en   = 1'b0;
    jmp_addr = '0;
    flush    = 1'b0;
    unique case (state)
      PCR_IDLE: begin
        flush = req;
        if (req && fetch_ready_i) begin
          jmp_en   = 1'b1;
          jmp_addr = sel_addr;
        end
      end
      PCR_PEND: begin
        // Branches here come from squashed instructions; only a trap may override.
        flush = trap_req_i;
        if (fetch_ready_i) begin
          jmp_en   = 1'b1;
          jmp_addr = trap_req_i ? trap_al : pend_addr;
        end
      end
      default: ;
    endcase
    hold = (hold_ex_i | hold_id_i | ~fetch_ready_i | (state == PCR_PEND)) & ~jmp_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PCR_IDLE;
      pend_addr <= '0;
    end else begin
      unique case (state)
        PCR_IDLE: begin
          if (req && !fetch_ready_i) begin
            pend_addr <= sel_addr;
            state     <= PCR_PEND;
          end
        end
        PCR_PEND: begin
          if (fetch_ready_i)   state     <= PCR_IDLE;
          else if (trap_req_i) pend_addr <= trap_al;
        end
        default: state <= PCR_IDLE;
      endcase
    end
  end

  fetch_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fetch_watchdog (
    .clk           (clk),
    .rst           (rst),
    .fetch_ready_i (fetch_ready_i),
    .bus_err_o     (wd_err)
  );

  // Reset forces every output low in the same cycle, including combinational paths.
  assign jmp_en_o   = jmp_en & ~rst;
  assign jmp_addr_o = rst ? '0 : jmp_addr;
  assign hold_o     = hold & ~rst;
  assign flush_o    = flush & ~rst;
  assign pend_o     = (state == PCR_PEND) & ~rst;
  assign bus_err_o  = wd_err & ~rst;

endmodule
